// File: rtl/seg_refresh_scanner_if.sv
// Load port for the 7-segment refresh scanner: one 32-bit hex word per
// valid/ready transfer.
interface seg_refresh_scanner_if;
  logic [31:0] load_data;
  logic        load_valid;
  logic        load_ready;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready
  );
endinterface

// File: rtl/seg_refresh_scanner.sv
// Multiplexed 8-digit 7-segment scanner with a double-buffered display word,
// frame-aligned commits and optional leading-zero blanking.
module seg_refresh_scanner #(
  parameter int TICK_DIV = 100_000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  seg_refresh_scanner_if.slave         load,
  output logic [2:0]                   refreshcounter,
  output logic [6:0]                   seg_n,
  output logic                         frame_done
);

  localparam int          CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] prescaler;
  logic          tick;
  logic          wrap;
  logic          commit;
  logic          transfer;

  logic [31:0]   active;
  logic [31:0]   pending;
  logic          pending_full;

  logic [2:0]    next_idx;
  logic [31:0]   next_active;
  logic [31:0]   upper;
  logic [6:0]    seg_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick     = (prescaler == LAST);
  assign wrap     = tick & (refreshcounter == 3'd7);
  assign commit   = wrap & pending_full;

  // A commit frees the pending slot in the same cycle, so a waiting word
  // can be taken on the commit edge without a bubble.
  assign load.load_ready = ~pending_full | commit;
  assign transfer        = load.load_valid & load.load_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // NOTE: every variable gets a default at the top of an always_comb so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    next_idx    = refreshcounter;
    next_active = active;
    if (tick) begin
      next_idx = refreshcounter + 3'd1;
    end
    if (commit) begin
      next_active = pending;
    end
  end

  // Decode from the next index and next word so seg_n and refreshcounter
  // update on the same edge; upper[3:0] is the selected nibble.
  always_comb begin
    upper    = next_active >> {next_idx, 2'b00};
    seg_next = hex_to_seg(upper[3:0]);
    if (LZ_BLANK && (next_idx != 3'd0) && (upper == 32'h0)) begin
      seg_next = 7'h7F;
    end
  end

  // NOTE: the display words are reset, not left undefined, so the first
  // frame after reset decodes a known all-zero word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refreshcounter <= 3'd0;
      seg_n          <= 7'b1000000;
      frame_done     <= 1'b0;
      active         <= 32'h0;
      pending        <= 32'h0;
      pending_full   <= 1'b0;
    end else begin
      refreshcounter <= next_idx;
      seg_n          <= seg_next;
      frame_done     <= wrap;
      active         <= next_active;
      if (transfer) begin
        pending <= load.load_data;
      end
      pending_full   <= transfer | (pending_full & ~commit);
    end
  end

endmodule

// File: tb/tb_seg_refresh_scanner.sv
// Directed bench for seg_refresh_scanner: TICK_DIV = 4, one instance with
// leading-zero blanking and one without, driven with identical stimulus.
module tb_seg_refresh_scanner;

  typedef struct {
    logic [31:0]     word;
    logic [7:0][6:0] exp_lz;
    logic [7:0][6:0] exp_nlz;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] ld_data;
  logic        ld_valid;

  logic [2:0]  rc,  rc_nlz;
  logic [6:0]  seg, seg_nlz;
  logic        fd,  fd_nlz;

  int n_checks = 0;
  int n_fail   = 0;

  seg_refresh_scanner_if lif ();
  seg_refresh_scanner_if lif_nlz ();

  assign lif.load_data      = ld_data;
  assign lif.load_valid     = ld_valid;
  assign lif_nlz.load_data  = ld_data;
  assign lif_nlz.load_valid = ld_valid;

  seg_refresh_scanner #(.TICK_DIV(4), .LZ_BLANK(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (lif.slave),
    .refreshcounter (rc),
    .seg_n          (seg),
    .frame_done     (fd)
  );

  seg_refresh_scanner #(.TICK_DIV(4), .LZ_BLANK(1'b0)) dut_nlz (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (lif_nlz.slave),
    .refreshcounter (rc_nlz),
    .seg_n          (seg_nlz),
    .frame_done     (fd_nlz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until frame_done; the wrap must arrive exactly 32 clocks later.
  task automatic wait_wrap(input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!fd && n < 40);
    check(name, n, 32);
  endtask

  // Entered at the sample just after a wrap; checks one whole frame and
  // optionally loads a word mid-frame, which must not disturb this frame.
  task automatic check_frame(input string name, input logic [7:0][6:0] exp_lz,
                             input logic [7:0][6:0] exp_nlz, input logic do_load,
                             input logic [31:0] word);
    for (int c = 0; c < 32; c++) begin
      check($sformatf("%s idx c%0d", name, c), rc, 32'(c / 4));
      check($sformatf("%s seg c%0d", name, c), seg, exp_lz[c / 4]);
      check($sformatf("%s seg_nlz c%0d", name, c), seg_nlz, exp_nlz[c / 4]);
      check($sformatf("%s frame_done c%0d", name, c), fd, (c == 0) ? 1 : 0);
      if (do_load && c == 10) begin
        check($sformatf("%s ready before load", name), lif.load_ready, 1);
        ld_data  = word;
        ld_valid = 1'b1;
      end
      if (do_load && c == 11) begin
        check($sformatf("%s ready after load", name), lif.load_ready, 0);
        ld_valid = 1'b0;
      end
      step();
    end
  endtask

  vec_t            vecs[6];
  logic [7:0][6:0] prev_lz, prev_nlz;
  logic [7:0][6:0] zero_lz, zero_nlz;
  logic [7:0][6:0] a_lz, a_nlz, b_lz, b_nlz;
  logic [31:0]     word_a, word_b, word_c;
  int              n;

  initial begin
    zero_lz  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    zero_nlz = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    vecs[0].word    = 32'h0000_00A5;
    vecs[0].exp_lz  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12};
    vecs[0].exp_nlz = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12};
    vecs[1].word    = 32'h1234_5678;
    vecs[1].exp_lz  = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
    vecs[1].exp_nlz = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
    vecs[2].word    = 32'h0000_0000;
    vecs[2].exp_lz  = zero_lz;
    vecs[2].exp_nlz = zero_nlz;
    vecs[3].word    = 32'hDEAD_BEEF;
    vecs[3].exp_lz  = {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E};
    vecs[3].exp_nlz = {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E};
    vecs[4].word    = 32'h00F0_0900;
    vecs[4].exp_lz  = {7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h10, 7'h40, 7'h40};
    vecs[4].exp_nlz = {7'h40, 7'h40, 7'h0E, 7'h40, 7'h40, 7'h10, 7'h40, 7'h40};
    vecs[5].word    = 32'h8000_000C;
    vecs[5].exp_lz  = {7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h46};
    vecs[5].exp_nlz = {7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h46};

    word_a = 32'h0000_0012;
    a_lz   = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24};
    a_nlz  = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24};
    word_b = 32'h0000_0300;
    b_lz   = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h40};
    b_nlz  = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h30, 7'h40, 7'h40};
    word_c = 32'h0000_0777;

    // Reset values
    rst_n    = 1'b0;
    ld_data  = 32'h0;
    ld_valid = 1'b0;
    #12;
    check("reset idx", rc, 0);
    check("reset seg", seg, 7'h40);
    check("reset seg_nlz", seg_nlz, 7'h40);
    check("reset frame_done", fd, 0);
    check("reset ready", lif.load_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_wrap("first wrap cycles");

    // Table: each word is loaded mid-frame and must appear only after the wrap
    prev_lz  = zero_lz;
    prev_nlz = zero_nlz;
    for (int v = 0; v < 6; v++) begin
      check_frame($sformatf("vec%0d", v), prev_lz, prev_nlz, 1'b1, vecs[v].word);
      prev_lz  = vecs[v].exp_lz;
      prev_nlz = vecs[v].exp_nlz;
    end

    // Back-to-back loads: the second waits until the commit edge
    for (int c = 0; c < 32; c++) begin
      check($sformatf("b2b idx c%0d", c), rc, 32'(c / 4));
      check($sformatf("b2b seg c%0d", c), seg, prev_lz[c / 4]);
      if (c == 5) begin
        check("b2b ready first", lif.load_ready, 1);
        ld_data  = word_a;
        ld_valid = 1'b1;
      end else if (c >= 6 && c <= 20) begin
        check($sformatf("b2b ready stall c%0d", c), lif.load_ready, 0);
        ld_data = 32'hBADB_AD00;
      end else if (c >= 21 && c <= 30) begin
        check($sformatf("b2b ready stall c%0d", c), lif.load_ready, 0);
        ld_data = word_b;
      end else if (c == 31) begin
        check("b2b ready at commit", lif.load_ready, 1);
      end
      step();
    end
    ld_valid = 1'b0;
    check("b2b ready after commit", lif.load_ready, 0);
    check_frame("b2b first", a_lz, a_nlz, 1'b0, 32'h0);
    check("b2b ready after second commit", lif.load_ready, 1);
    check_frame("b2b second", b_lz, b_nlz, 1'b0, 32'h0);

    // Reset at index 5 with a pending word
    check("rst ready before load", lif.load_ready, 1);
    ld_data  = word_c;
    ld_valid = 1'b1;
    step();
    ld_valid = 1'b0;
    check("rst pending full", lif.load_ready, 0);
    n = 0;
    while (rc != 3'd5 && n < 40) begin
      step();
      n++;
    end
    check("rst reached idx 5", rc, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async idx", rc, 0);
    check("rst async seg", seg, 7'h40);
    check("rst async frame_done", fd, 0);
    check("rst async ready", lif.load_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst release ready", lif.load_ready, 1);
    check("rst release idx", rc, 0);
    wait_wrap("rst wrap cycles");
    check_frame("after rst", zero_lz, zero_nlz, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
